dac_stream_feeder: RTL and testbench

//  AXI4-Stream slave: receives offset-binary setpoint words and buffers them in a FIFO.

---
 rtl/dac_stream_feeder.sv | 147 ++++++++++++++
 tb/tb_dac_stream_feeder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dac_stream_feeder
// Brief    : AXIS setpoint FIFO paced to the DAC tick, offset-binary -> 2's comp
// Revision : 1.0
// ============================================================================
module dac_stream_feeder #(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      dac_s_axis_tdata,
    input  logic             dac_s_axis_tvalid,
    output logic             dac_s_axis_tready,
    input  logic             i_dac_tick,
    input  logic             i_dac_busy,
    output logic [23:0]      o_dac_data,
    output logic             o_dac_valid,
    output logic [LVL_W-1:0] o_fifo_level,
    output logic             o_underrun,
    output logic             o_tick_miss,
    input  logic             i_clr_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t           r_state;
    logic [23:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [23:0]      r_dac_data;
    logic             r_underrun;
    logic             r_tick_miss;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_set_underrun;
    logic             w_set_tick_miss;
    logic [23:0]      w_head;
    logic             w_unused_tdata_hi;

    assign w_unused_tdata_hi = ^dac_s_axis_tdata[31:24];

    assign dac_s_axis_tready = (r_level != LVL_W'(FIFO_DEPTH));
    assign w_empty           = (r_level == '0);
    assign w_push            = dac_s_axis_tvalid & dac_s_axis_tready;
    // Emptiness comes from the registered level, so a same-cycle push cannot feed a pop.
    assign w_pop             = (r_state == S_POP) & ~w_empty;
    assign w_head            = r_mem[r_rd_ptr];
    assign w_set_underrun    = (r_state == S_POP) & w_empty;
    assign w_set_tick_miss   = i_dac_tick & (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= dac_s_axis_tdata[23:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_dac_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_dac_tick) begin
                        r_state <= S_POP;
                    end
                end
                S_POP: begin
                    if (w_pop) begin
                        r_dac_data <= {~w_head[23], w_head[22:0]};
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!i_dac_busy) begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a clear takes priority.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_underrun  <= 1'b0;
            r_tick_miss <= 1'b0;
        end else begin
            if (w_set_underrun) begin
                r_underrun <= 1'b1;
            end else if (i_clr_flags) begin
                r_underrun <= 1'b0;
            end
            if (w_set_tick_miss) begin
                r_tick_miss <= 1'b1;
            end else if (i_clr_flags) begin
                r_tick_miss <= 1'b0;
            end
        end
    end

    assign o_dac_data   = r_dac_data;
    assign o_dac_valid  = (r_state == S_SEND);
    assign o_fifo_level = r_level;
    assign o_underrun   = r_underrun;
    assign o_tick_miss  = r_tick_miss;

endmodule
`default_nettype wire

// File: tb/tb_dac_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_stream_feeder
// Brief    : Directed self-checking bench for dac_stream_feeder
// Revision : 1.0
// ============================================================================
module tb_dac_stream_feeder;

    localparam int FIFO_DEPTH = 16;
    localparam int LVL_W      = 5;

    logic             i_clk;
    logic             i_rst;
    logic [31:0]      dac_s_axis_tdata;
    logic             dac_s_axis_tvalid;
    logic             dac_s_axis_tready;
    logic             i_dac_tick;
    logic             i_dac_busy;
    logic [23:0]      o_dac_data;
    logic             o_dac_valid;
    logic [LVL_W-1:0] o_fifo_level;
    logic             o_underrun;
    logic             o_tick_miss;
    logic             i_clr_flags;

    int n_checks;
    int n_errors;

    dac_stream_feeder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) u_dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .dac_s_axis_tdata  (dac_s_axis_tdata),
        .dac_s_axis_tvalid (dac_s_axis_tvalid),
        .dac_s_axis_tready (dac_s_axis_tready),
        .i_dac_tick        (i_dac_tick),
        .i_dac_busy        (i_dac_busy),
        .o_dac_data        (o_dac_data),
        .o_dac_valid       (o_dac_valid),
        .o_fifo_level      (o_fifo_level),
        .o_underrun        (o_underrun),
        .o_tick_miss       (o_tick_miss),
        .i_clr_flags       (i_clr_flags)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [23:0] d);
        dac_s_axis_tdata  = {8'hA5, d};
        dac_s_axis_tvalid = 1'b1;
        chk("push_tready", {31'd0, dac_s_axis_tready}, 32'd1);
        cyc();
        dac_s_axis_tvalid = 1'b0;
    endtask

    // Tick with busy low; leaves the bench in the SEND cycle.
    task automatic tick_to_send();
        i_dac_tick = 1'b1;
        cyc();
        i_dac_tick = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        i_rst             = 1'b0;
        dac_s_axis_tdata  = '0;
        dac_s_axis_tvalid = 1'b0;
        i_dac_tick        = 1'b0;
        i_dac_busy        = 1'b0;
        i_clr_flags       = 1'b0;

        // Reset values
        cyc();
        cyc();
        chk("rst_data",   {8'd0, o_dac_data}, 32'h0);
        chk("rst_valid",  {31'd0, o_dac_valid}, 32'd0);
        chk("rst_level",  {27'd0, o_fifo_level}, 32'd0);
        chk("rst_undr",   {31'd0, o_underrun}, 32'd0);
        chk("rst_miss",   {31'd0, o_tick_miss}, 32'd0);
        chk("rst_tready", {31'd0, dac_s_axis_tready}, 32'd1);
        #3 i_rst = 1'b1;
        cyc();

        // 1: midscale word, exact valid latency
        push(24'h800000);
        chk("t1_level1", {27'd0, o_fifo_level}, 32'd1);
        i_dac_tick = 1'b1;
        cyc();
        i_dac_tick = 1'b0;
        chk("t1_valid_t1", {31'd0, o_dac_valid}, 32'd0);
        cyc();
        chk("t1_valid_t2", {31'd0, o_dac_valid}, 32'd0);
        chk("t1_level0",   {27'd0, o_fifo_level}, 32'd0);
        cyc();
        chk("t1_valid_t3", {31'd0, o_dac_valid}, 32'd1);
        chk("t1_data",     {8'd0, o_dac_data}, 32'h000000);
        cyc();
        chk("t1_valid_t4", {31'd0, o_dac_valid}, 32'd0);

        // 2: three words, ticks 10 cycles apart
        push(24'hFFFFFF);
        push(24'h000000);
        push(24'hC00000);
        chk("t2_level3", {27'd0, o_fifo_level}, 32'd3);
        tick_to_send();
        chk("t2_v0", {31'd0, o_dac_valid}, 32'd1);
        chk("t2_d0", {8'd0, o_dac_data}, 32'h7FFFFF);
        repeat (7) cyc();
        tick_to_send();
        chk("t2_v1", {31'd0, o_dac_valid}, 32'd1);
        chk("t2_d1", {8'd0, o_dac_data}, 32'h800000);
        repeat (7) cyc();
        tick_to_send();
        chk("t2_v2", {31'd0, o_dac_valid}, 32'd1);
        chk("t2_d2", {8'd0, o_dac_data}, 32'h400000);
        chk("t2_undr", {31'd0, o_underrun}, 32'd0);
        cyc();

        // 3: fill to full with tvalid held high
        dac_s_axis_tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dac_s_axis_tdata = 32'h00100000 + i;
            cyc();
        end
        chk("t3_level16", {27'd0, o_fifo_level}, 32'd16);
        chk("t3_tready0", {31'd0, dac_s_axis_tready}, 32'd0);
        dac_s_axis_tdata = 32'h00ABCDEF;
        cyc();
        cyc();
        chk("t3_stall_lvl", {27'd0, o_fifo_level}, 32'd16);
        i_dac_tick = 1'b1;
        cyc();
        i_dac_tick = 1'b0;
        chk("t3_pop_tready", {31'd0, dac_s_axis_tready}, 32'd0);
        cyc();
        chk("t3_after_tready", {31'd0, dac_s_axis_tready}, 32'd1);
        chk("t3_after_lvl",    {27'd0, o_fifo_level}, 32'd15);
        cyc();
        dac_s_axis_tvalid = 1'b0;
        chk("t3_w17_lvl", {27'd0, o_fifo_level}, 32'd16);
        chk("t3_v",       {31'd0, o_dac_valid}, 32'd1);
        chk("t3_d",       {8'd0, o_dac_data}, 32'h900000);
        cyc();

        // 4: drain, last real word 0x123456, then underrun repeat
        for (int i = 1; i < 16; i++) begin
            tick_to_send();
            chk("t4_drain", {8'd0, o_dac_data}, 32'h900000 + i);
            cyc();
        end
        tick_to_send();
        chk("t4_w17", {8'd0, o_dac_data}, 32'h2BCDEF);
        cyc();
        push(24'h923456);
        tick_to_send();
        chk("t4_last", {8'd0, o_dac_data}, 32'h123456);
        chk("t4_empty", {27'd0, o_fifo_level}, 32'd0);
        chk("t4_undr_pre", {31'd0, o_underrun}, 32'd0);
        cyc();
        tick_to_send();
        chk("t4_uv", {31'd0, o_dac_valid}, 32'd1);
        chk("t4_ud", {8'd0, o_dac_data}, 32'h123456);
        chk("t4_undr", {31'd0, o_underrun}, 32'd1);
        i_clr_flags = 1'b1;
        cyc();
        i_clr_flags = 1'b0;
        chk("t4_clr", {31'd0, o_underrun}, 32'd0);

        // 5: busy stretch and a missed tick
        push(24'h000001);
        push(24'h000002);
        i_dac_tick = 1'b1;
        cyc();
        i_dac_tick = 1'b0;
        cyc();
        i_dac_busy = 1'b1;
        cyc();
        i_dac_tick = 1'b1;
        cyc();
        i_dac_tick = 1'b0;
        chk("t5_miss", {31'd0, o_tick_miss}, 32'd1);
        cyc();
        cyc();
        cyc();
        i_dac_busy = 1'b0;
        chk("t5_v7", {31'd0, o_dac_valid}, 32'd0);
        cyc();
        chk("t5_v8", {31'd0, o_dac_valid}, 32'd1);
        chk("t5_d",  {8'd0, o_dac_data}, 32'h800001);
        chk("t5_lvl", {27'd0, o_fifo_level}, 32'd1);
        i_clr_flags = 1'b1;
        cyc();
        i_clr_flags = 1'b0;
        chk("t5_clr", {31'd0, o_tick_miss}, 32'd0);

        // 6: async reset while in WAIT with level 7
        for (int i = 0; i < 7; i++) push(24'h000010 + 24'(i));
        i_dac_busy = 1'b1;
        i_dac_tick = 1'b1;
        cyc();
        i_dac_tick = 1'b0;
        cyc();
        cyc();
        chk("t6_lvl7", {27'd0, o_fifo_level}, 32'd7);
        chk("t6_d",    {8'd0, o_dac_data}, 32'h800002);
        #2 i_rst = 1'b0;
        #1;
        chk("t6_data0",  {8'd0, o_dac_data}, 32'h0);
        chk("t6_lvl0",   {27'd0, o_fifo_level}, 32'd0);
        chk("t6_tready", {31'd0, dac_s_axis_tready}, 32'd1);
        chk("t6_valid0", {31'd0, o_dac_valid}, 32'd0);
        i_dac_busy = 1'b0;
        cyc();
        #3 i_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t6_novalid", {31'd0, o_dac_valid}, 32'd0);
        end
        chk("t6_lvl_post", {27'd0, o_fifo_level}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
